// File: rtl/binoc_pkg.sv
// Shared types for the BiNoC local injection NI: packet layout, lane state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package binoc_pkg;

  localparam int PKT_W = 32;

  // Lane index used throughout the NI: lane 0 carries HP, lane 1 carries LP.
  localparam int LANE_HP = 0;
  localparam int LANE_LP = 1;

  // Bit layout of a packet, MSB first: [31:28] dst, [27:26] src_x,
  // [25:24] src_y, [23:20] seq, [19:0] payload.
  typedef struct packed {
    logic [3:0]  dst;
    logic [1:0]  src_x;
    logic [1:0]  src_y;
    logic [3:0]  seq;
    logic [19:0] payload;
  } binoc_packet_t;

  typedef enum logic {
    NI_IDLE = 1'b0,
    NI_REQ  = 1'b1
  } ni_state_e;

endpackage

// File: rtl/binoc_ni_inject_if.sv
// Core-side offer and router-side HP/LP req/gnt bundle of the injection NI.
// Latency: n/a (wiring only).
// Backpressure: core_ready toward the core, gnt/full from the router.
// Modports: slave = the NI itself, master = the core plus router it talks to.
interface binoc_ni_inject_if;
  import binoc_pkg::*;

  logic             core_valid;
  logic             core_ready;
  logic             core_prio;
  logic [3:0]       core_dst;
  logic [19:0]      core_payload;
  logic             local_HP_input_req;
  logic             local_HP_input_gnt;
  logic             local_LP_input_req;
  logic             local_LP_input_gnt;
  logic             local_full_0;
  logic             local_full_1;
  logic [PKT_W-1:0] localPacket_0;
  logic [PKT_W-1:0] localPacket_1;

  modport slave (
    input  core_valid, core_prio, core_dst, core_payload,
    input  local_HP_input_gnt, local_LP_input_gnt, local_full_0, local_full_1,
    output core_ready, local_HP_input_req, local_LP_input_req,
    output localPacket_0, localPacket_1
  );

  modport master (
    output core_valid, core_prio, core_dst, core_payload,
    output local_HP_input_gnt, local_LP_input_gnt, local_full_0, local_full_1,
    input  core_ready, local_HP_input_req, local_LP_input_req,
    input  localPacket_0, localPacket_1
  );

endinterface

// File: rtl/binoc_ni_fifo.sv
// Synchronous FIFO with combinational head (dout = oldest entry).
// Latency: a push is visible on dout/empty the cycle after its edge.
// Backpressure: push ignored when full, pop ignored when empty; both at once keep count.
// Ports: clk/rst, push/din write side, pop/dout read side, full/empty/count status.
module binoc_ni_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/binoc_ni_inject.sv
// Local-port injection NI: formats core offers into packets, queues per priority, drives router req/gnt.
// Latency: push at edge t -> req and packet valid the following cycle; 1 packet/cycle per lane under gnt.
// Backpressure: core_ready = !full of the FIFO chosen by core_prio; req held until gnt regardless of full.
// Ports: clk, rst (async, active-high), ni (slave side of binoc_ni_inject_if).
// Optional: BINOC_NI_SEQ_EN inserts a per-lane 4-bit push counter into the seq field.
module binoc_ni_inject import binoc_pkg::*; #(
  parameter int         DEPTH = 4,
  parameter logic [1:0] SRC_X = 2'd0,
  parameter logic [1:0] SRC_Y = 2'd0
) (
  input  logic             clk,
  input  logic             rst,
  binoc_ni_inject_if.slave ni
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]       gnt, full_in, push, pop, req, fifo_full, fifo_empty;
  logic [PKT_W-1:0] fifo_dout [2];
  logic [PKT_W-1:0] pkt_out   [2];
  logic [CW-1:0]    fifo_count[2];
  logic             lane_sel;
  logic [3:0]       seq_cur;
  binoc_packet_t    pkt_fmt;

  assign gnt      = {ni.local_LP_input_gnt, ni.local_HP_input_gnt};
  assign full_in  = {ni.local_full_1, ni.local_full_0};
  assign lane_sel = !ni.core_prio;

  assign ni.core_ready = !fifo_full[lane_sel];
  assign push[LANE_HP] = ni.core_valid &&  ni.core_prio && !fifo_full[LANE_HP];
  assign push[LANE_LP] = ni.core_valid && !ni.core_prio && !fifo_full[LANE_LP];

`ifdef BINOC_NI_SEQ_EN
  // The stamped value is the count before this push, so the first packet carries 0.
  logic [3:0] seq_q [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < 2; l++) seq_q[l] <= 4'h0;
    end else begin
      for (int l = 0; l < 2; l++) if (push[l]) seq_q[l] <= seq_q[l] + 4'd1;
    end
  end

  assign seq_cur = seq_q[lane_sel];
`else
  assign seq_cur = 4'h0;
`endif

  always_comb begin
    pkt_fmt         = '0;
    pkt_fmt.dst     = ni.core_dst;
    pkt_fmt.src_x   = SRC_X;
    pkt_fmt.src_y   = SRC_Y;
    pkt_fmt.seq     = seq_cur;
    pkt_fmt.payload = ni.core_payload;
  end

  for (genvar l = 0; l < 2; l++) begin : g_lane
    ni_state_e        state_q, state_d;
    logic [PKT_W-1:0] hold_q;
    logic             avail;

    binoc_ni_fifo #(.DEPTH(DEPTH), .W(PKT_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[l]),
      .pop   (pop[l]),
      .din   (pkt_fmt),
      .dout  (fifo_dout[l]),
      .full  (fifo_full[l]),
      .empty (fifo_empty[l]),
      .count (fifo_count[l])
    );

    assign req[l] = (state_q == NI_REQ);
    assign pop[l] = req[l] && gnt[l];

    // FIFO occupancy after this edge's push/pop land. Looking ahead here lets
    // req rise the cycle right after a push and keeps a lane streaming while
    // gnt stays high.
    assign avail = push[l] || (fifo_count[l] > CW'(pop[l]));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= NI_IDLE;
      else     state_q <= state_d;
    end

    // A full that rises while requesting is not looked at until gnt arrives.
    always_comb begin
      state_d = state_q;
      case (state_q)
        NI_IDLE: if (avail && !full_in[l]) state_d = NI_REQ;
        NI_REQ:  if (gnt[l]) state_d = (avail && !full_in[l]) ? NI_REQ : NI_IDLE;
        default: state_d = NI_IDLE;
      endcase
    end

    // Keeps the last head on the output once the lane drains.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                 hold_q <= '0;
      else if (!fifo_empty[l]) hold_q <= fifo_dout[l];
    end

    assign pkt_out[l] = fifo_empty[l] ? hold_q : fifo_dout[l];
  end

  assign ni.local_HP_input_req = req[LANE_HP];
  assign ni.local_LP_input_req = req[LANE_LP];
  assign ni.localPacket_0      = pkt_out[LANE_HP];
  assign ni.localPacket_1      = pkt_out[LANE_LP];

endmodule

// File: tb/tb_binoc_ni_inject.sv
// Self-checking bench for binoc_ni_inject: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
// Build with BINOC_NI_SEQ_EN defined to cover the sequence-stamping variant.
module tb_binoc_ni_inject;
  import binoc_pkg::*;

  localparam int DEPTH = 4;
`ifdef BINOC_NI_SEQ_EN
  localparam bit SEQ_ON = 1'b1;
`else
  localparam bit SEQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  binoc_ni_inject_if ifc();

  binoc_ni_inject #(.DEPTH(DEPTH), .SRC_X(2'd0), .SRC_Y(2'd0)) dut (
    .clk (clk),
    .rst (rst),
    .ni  (ifc)
  );

  int total = 0;
  int bad   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- reference model (lane 0 = HP, lane 1 = LP) ----------------
  typedef logic [31:0] wq_t[$];
  wq_t         mq[2];
  bit          req_m[2];
  logic [31:0] last_m[2];
  logic [3:0]  seq_m[2];
  logic [31:0] hp_log[$];

  function automatic logic [31:0] fmt(input logic [3:0] d, input logic [3:0] s, input logic [19:0] p);
    return {d, 2'd0, 2'd0, (SEQ_ON ? s : 4'h0), p};
  endfunction

  initial begin : model
    int  pl;
    bit  g[2];
    bit  f[2];
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int l = 0; l < 2; l++) begin
          mq[l].delete();
          req_m[l]  = 1'b0;
          last_m[l] = 32'h0;
          seq_m[l]  = 4'h0;
        end
      end else begin
        g[0] = ifc.local_HP_input_gnt;
        g[1] = ifc.local_LP_input_gnt;
        f[0] = ifc.local_full_0;
        f[1] = ifc.local_full_1;
        pl   = ifc.core_prio ? 0 : 1;
        for (int l = 0; l < 2; l++) begin
          if (mq[l].size() > 0) last_m[l] = mq[l][0];
          if (req_m[l] && g[l] && mq[l].size() > 0) void'(mq[l].pop_front());
        end
        // Acceptance is judged on the occupancy seen before this edge's pop.
        if (ifc.core_valid && (mq[pl].size() + ((req_m[pl] && g[pl]) ? 1 : 0)) < DEPTH) begin
          mq[pl].push_back(fmt(ifc.core_dst, seq_m[pl], ifc.core_payload));
          seq_m[pl] = seq_m[pl] + 4'd1;
        end
        for (int l = 0; l < 2; l++) begin
          if (!(req_m[l] && !g[l])) req_m[l] = (mq[l].size() > 0) && !f[l];
        end
      end
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  initial begin : compare
    int lane;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        check1("rst_ready", ifc.core_ready, 1'b1);
        check1("rst_hp_req", ifc.local_HP_input_req, 1'b0);
        check1("rst_lp_req", ifc.local_LP_input_req, 1'b0);
        check32("rst_pkt0", ifc.localPacket_0, 32'h0);
        check32("rst_pkt1", ifc.localPacket_1, 32'h0);
      end else begin
        lane = ifc.core_prio ? 0 : 1;
        check1("m_ready", ifc.core_ready, mq[lane].size() < DEPTH);
        check1("m_hp_req", ifc.local_HP_input_req, req_m[0]);
        check1("m_lp_req", ifc.local_LP_input_req, req_m[1]);
        check32("m_pkt0", ifc.localPacket_0, (mq[0].size() > 0) ? mq[0][0] : last_m[0]);
        check32("m_pkt1", ifc.localPacket_1, (mq[1].size() > 0) ? mq[1][0] : last_m[1]);
        if (ifc.local_HP_input_req && ifc.local_HP_input_gnt) hp_log.push_back(ifc.localPacket_0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic p, input logic [3:0] d, input logic [19:0] pl);
    ifc.core_valid   = 1'b1;
    ifc.core_prio    = p;
    ifc.core_dst     = d;
    ifc.core_payload = pl;
  endtask

  task automatic idle();
    ifc.core_valid = 1'b0;
  endtask

  logic [31:0] lp_exp[4];
  int          base;

  initial begin : stim
    rst                    = 1'b1;
    ifc.core_valid         = 1'b0;
    ifc.core_prio          = 1'b0;
    ifc.core_dst           = 4'h0;
    ifc.core_payload       = 20'h0;
    ifc.local_HP_input_gnt = 1'b0;
    ifc.local_LP_input_gnt = 1'b0;
    ifc.local_full_0       = 1'b0;
    ifc.local_full_1       = 1'b0;
    lp_exp[0] = 32'h1000_0100;
    lp_exp[1] = SEQ_ON ? 32'h2010_0101 : 32'h2000_0101;
    lp_exp[2] = SEQ_ON ? 32'h3020_0102 : 32'h3000_0102;
    lp_exp[3] = SEQ_ON ? 32'h4030_0103 : 32'h4000_0103;
    repeat (2) tick();
    rst = 1'b0;
    tick(); #3;
    check1("reset_ready", ifc.core_ready, 1'b1);
    check1("reset_hp_req", ifc.local_HP_input_req, 1'b0);
    check1("reset_lp_req", ifc.local_LP_input_req, 1'b0);
    check32("reset_pkt0", ifc.localPacket_0, 32'h0);
    check32("reset_pkt1", ifc.localPacket_1, 32'h0);

    // single HP packet, granted one cycle after req
    tick(); drive(1'b1, 4'h5, 20'h00029);
    tick(); idle(); ifc.local_HP_input_gnt = 1'b1; #3;
    check1("t1_req", ifc.local_HP_input_req, 1'b1);
    check32("t1_pkt", ifc.localPacket_0, 32'h5000_0029);
    tick(); ifc.local_HP_input_gnt = 1'b0; #3;
    check1("t1_req_drop", ifc.local_HP_input_req, 1'b0);
    check32("t1_pkt_hold", ifc.localPacket_0, 32'h5000_0029);

    // fill LP, HP still accepted, then drain LP back to back
    for (int i = 0; i < 4; i++) begin
      tick(); drive(1'b0, 4'(i + 1), 20'h00100 + 20'(i));
    end
    tick(); idle(); ifc.core_prio = 1'b0; #3;
    check1("t2_lp_ready_full", ifc.core_ready, 1'b0);
    check1("t2_lp_req", ifc.local_LP_input_req, 1'b1);
    drive(1'b1, 4'hA, 20'h00ABC); #1;
    check1("t2_hp_ready", ifc.core_ready, 1'b1);
    tick(); idle(); #3;
    check1("t2_hp_req", ifc.local_HP_input_req, 1'b1);
    ifc.local_HP_input_gnt = 1'b1;
    tick(); ifc.local_HP_input_gnt = 1'b0;
    ifc.local_LP_input_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      check32($sformatf("t2_drain%0d", i), ifc.localPacket_1, lp_exp[i]);
      check1($sformatf("t2_drain_req%0d", i), ifc.local_LP_input_req, 1'b1);
      tick();
    end
    ifc.local_LP_input_gnt = 1'b0; #3;
    check1("t2_drained_req", ifc.local_LP_input_req, 1'b0);
    check32("t2_drained_hold", ifc.localPacket_1, lp_exp[3]);

    // router full blocks a new request but never retracts an asserted one
    tick(); ifc.local_full_1 = 1'b1; drive(1'b0, 4'h6, 20'h00200);
    tick(); idle(); #3;
    check1("t3_blocked", ifc.local_LP_input_req, 1'b0);
    tick(); ifc.local_full_1 = 1'b0; #3;
    check1("t3_blocked2", ifc.local_LP_input_req, 1'b0);
    tick(); #3;
    check1("t3_release", ifc.local_LP_input_req, 1'b1);
    tick(); ifc.local_full_1 = 1'b1; #3;
    check1("t3_full_in_req", ifc.local_LP_input_req, 1'b1);
    tick(); #3;
    check1("t3_full_in_req2", ifc.local_LP_input_req, 1'b1);
    ifc.local_LP_input_gnt = 1'b1;
    tick(); ifc.local_LP_input_gnt = 1'b0; ifc.local_full_1 = 1'b0; #3;
    check1("t3_after_gnt", ifc.local_LP_input_req, 1'b0);

    // both lanes loaded, granted on the same cycle
    tick(); drive(1'b1, 4'h7, 20'h00300);
    tick(); drive(1'b0, 4'h8, 20'h00301);
    tick(); idle(); #3;
    check1("t4_hp_req", ifc.local_HP_input_req, 1'b1);
    check1("t4_lp_req", ifc.local_LP_input_req, 1'b1);
    check32("t4_pkt0", ifc.localPacket_0, SEQ_ON ? 32'h7020_0300 : 32'h7000_0300);
    check32("t4_pkt1", ifc.localPacket_1, SEQ_ON ? 32'h8050_0301 : 32'h8000_0301);
    ifc.local_HP_input_gnt = 1'b1; ifc.local_LP_input_gnt = 1'b1;
    tick(); ifc.local_HP_input_gnt = 1'b0; ifc.local_LP_input_gnt = 1'b0; #3;
    check1("t4_hp_done", ifc.local_HP_input_req, 1'b0);
    check1("t4_lp_done", ifc.local_LP_input_req, 1'b0);

    // reset while requesting with three packets queued
    for (int i = 0; i < 3; i++) begin
      tick(); drive(1'b0, 4'h9, 20'h00400 + 20'(i));
    end
    tick(); idle(); #3;
    check1("t6_req_before", ifc.local_LP_input_req, 1'b1);
    #1 rst = 1'b1;
    #1;
    check1("t6_req_async", ifc.local_LP_input_req, 1'b0);
    check32("t6_pkt_async", ifc.localPacket_1, 32'h0);
    tick(); rst = 1'b0;
    repeat (3) tick();
    #3;
    check1("t6_no_lp_req", ifc.local_LP_input_req, 1'b0);
    check1("t6_no_hp_req", ifc.local_HP_input_req, 1'b0);
    check1("t6_ready", ifc.core_ready, 1'b1);

    // 17 HP packets streamed with gnt held high
    base = hp_log.size();
    ifc.local_HP_input_gnt = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick(); drive(1'b1, 4'h3, 20'(i));
    end
    tick(); idle();
    for (int k = 0; k < 40 && hp_log.size() < base + 17; k++) tick();
    ifc.local_HP_input_gnt = 1'b0;
    check32("t5_count", 32'(hp_log.size() - base), 32'd17);
    for (int i = 0; i < 17 && base + i < hp_log.size(); i++) begin
      check32($sformatf("t5_pkt%0d", i), hp_log[base + i],
              {4'h3, 4'h0, (SEQ_ON ? 4'(i % 16) : 4'h0), 20'(i)});
    end
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
